cacheline_adapter: RTL

Burst adapter between the data cache and main memory. On a miss it collects a 256-bit line from memory as four 64-bit beats and presents it on `line_o`, which the cache control writes into the data array `din` on the `resp_o` cycle. On a dirty eviction it takes the 256-bit line read from the data array and streams it to memory as four beats. One request is in flight at a time; the cache controller holds its request until `resp_o`.

---
 rtl/cacheline_adapter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/cacheline_adapter.sv
// Burst adapter between the data cache and main memory: assembles fill lines
// from memory beats and streams dirty lines back out, one request at a time.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no request in flight, waiting for read_i / write_i
// RD_BURST | collecting fill beats from memory into line_o
// RD_DONE  | fill line complete, resp_o pulse
// WR_BURST | streaming the buffered line to memory, one beat per resp_i
// WR_DONE  | writeback complete, resp_o pulse
module cacheline_adapter #(
    parameter int block_size  = 256,
    parameter int burst_width = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            addr_i,
    input  logic                   read_i,
    input  logic                   write_i,
    input  logic [block_size-1:0]  line_i,
    output logic [block_size-1:0]  line_o,
    output logic                   resp_o,
    output logic [31:0]            address_o,
    output logic                   read_o,
    output logic                   write_o,
    output logic [burst_width-1:0] burst_o,
    input  logic [burst_width-1:0] burst_i,
    input  logic                   resp_i
);

    localparam int beats = block_size / burst_width;
    localparam int cw    = $clog2(beats);
    localparam int off   = $clog2(block_size / 8);
    localparam logic [cw-1:0] last_beat = cw'(beats - 1);
    localparam logic [31:0]   addr_mask = ~((32'd1 << off) - 32'd1);

    typedef enum logic [2:0] {
        IDLE,
        RD_BURST,
        RD_DONE,
        WR_BURST,
        WR_DONE
    } state_t;

    state_t                  state, state_nxt;
    logic [cw-1:0]           count;
    logic [31:0]             addr_q;
    logic [block_size-1:0]   wline;
    logic [block_size-1:0]   line_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (write_i) begin
                    state_nxt = WR_BURST;
                end else if (read_i) begin
                    state_nxt = RD_BURST;
                end
            end
            RD_BURST: begin
                if (resp_i && count == last_beat) begin
                    state_nxt = RD_DONE;
                end
            end
            WR_BURST: begin
                if (resp_i && count == last_beat) begin
                    state_nxt = WR_DONE;
                end
            end
            RD_DONE:  state_nxt = IDLE;
            WR_DONE:  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // The beat counter wraps back to 0 on the last beat, so burst_o rests on
    // beat 0 after a writeback instead of running off the end of the line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            addr_q <= '0;
            wline  <= '0;
            line_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (write_i) begin
                        addr_q <= addr_i & addr_mask;
                        wline  <= line_i;
                        count  <= '0;
                    end else if (read_i) begin
                        addr_q <= addr_i & addr_mask;
                        count  <= '0;
                    end
                end
                RD_BURST: begin
                    if (resp_i) begin
                        line_q[count*burst_width +: burst_width] <= burst_i;
                        count <= count + 1'b1;
                    end
                end
                WR_BURST: begin
                    if (resp_i) begin
                        count <= count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign read_o    = (state == RD_BURST);
    assign write_o   = (state == WR_BURST);
    assign resp_o    = (state == RD_DONE) || (state == WR_DONE);
    assign address_o = (state == IDLE) ? 32'd0 : addr_q;
    assign burst_o   = wline[count*burst_width +: burst_width];
    assign line_o    = line_q;

endmodule
